// File: rtl/collision_scheduler_pkg.sv
// ============================================================================
//  Package     : collision_pkg
//  Description : Shared box type, coordinate width and scan FSM states for
//                collision_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package collision_pkg;

    localparam int POS_W = 12;

    typedef struct packed {
        logic [POS_W-1:0] x1;
        logic [POS_W-1:0] y1;
        logic [POS_W-1:0] x2;
        logic [POS_W-1:0] y2;
    } box_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/collision_scheduler_if.sv
// ============================================================================
//  Interface   : collision_if
//  Description : Box-write, scan-control and result bus of collision_scheduler.
//                COLLISION_IRQ_EN adds irq / irq_ack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface collision_if #(
    parameter int NUM_OBJ = 8,
    parameter int POS_W   = collision_pkg::POS_W
);
    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_act;
    logic [POS_W-1:0]   wr_x1;
    logic [POS_W-1:0]   wr_y1;
    logic [POS_W-1:0]   wr_x2;
    logic [POS_W-1:0]   wr_y2;
    logic               start;
    logic               busy;
    logic               done;
    logic [NUM_OBJ-1:0] hit_mask;
    logic               pair_vld;
    logic [IDX_W-1:0]   pair_a;
    logic [IDX_W-1:0]   pair_b;
`ifdef COLLISION_IRQ_EN
    logic               irq;
    logic               irq_ack;

    modport master (
        output wr_en, wr_idx, wr_act, wr_x1, wr_y1, wr_x2, wr_y2, start, irq_ack,
        input  busy, done, hit_mask, pair_vld, pair_a, pair_b, irq
    );
    modport slave (
        input  wr_en, wr_idx, wr_act, wr_x1, wr_y1, wr_x2, wr_y2, start, irq_ack,
        output busy, done, hit_mask, pair_vld, pair_a, pair_b, irq
    );
`else
    modport master (
        output wr_en, wr_idx, wr_act, wr_x1, wr_y1, wr_x2, wr_y2, start,
        input  busy, done, hit_mask, pair_vld, pair_a, pair_b
    );
    modport slave (
        input  wr_en, wr_idx, wr_act, wr_x1, wr_y1, wr_x2, wr_y2, start,
        output busy, done, hit_mask, pair_vld, pair_a, pair_b
    );
`endif

endinterface

`default_nettype wire

// File: rtl/collision_scheduler_cmp.sv
// ============================================================================
//  Module      : box_overlap_cmp
//  Description : Combinational strict axis-aligned overlap test of two boxes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module box_overlap_cmp
    import collision_pkg::*;
(
    input  box_t a_i,
    input  box_t b_i,
    output logic overlap_o
);

    logic a_ok;
    logic b_ok;
    logic axes_ok;

    // Degenerate boxes would otherwise satisfy the interval test against a large box.
    assign a_ok    = (a_i.x1 < a_i.x2) && (a_i.y1 < a_i.y2);
    assign b_ok    = (b_i.x1 < b_i.x2) && (b_i.y1 < b_i.y2);
    assign axes_ok = (a_i.x1 < b_i.x2) && (a_i.x2 > b_i.x1) &&
                     (a_i.y1 < b_i.y2) && (a_i.y2 > b_i.y1);

    assign overlap_o = a_ok && b_ok && axes_ok;

endmodule

`default_nettype wire

// File: rtl/collision_scheduler.sv
// ============================================================================
//  Module      : collision_scheduler
//  Description : Scans every unordered pair of a NUM_OBJ box table through one
//                registered overlap comparator; optional irq via COLLISION_IRQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module collision_scheduler
    import collision_pkg::*;
#(
    parameter int NUM_OBJ = 8
)(
    input  wire         clk,
    input  wire         reset_n,
    collision_if.slave  bus
);

    localparam int              IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_OBJ - 2);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_OBJ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
    logic               issue;
    logic               start_ok;
    logic               wr_ok;

    box_t               tbl_q [NUM_OBJ];
    logic [NUM_OBJ-1:0] act_q;
    box_t               wr_box;
    logic               overlap;
    logic               hit;

    logic [NUM_OBJ-1:0] hit_mask_q;
    logic               pair_vld_q;
    logic [IDX_W-1:0]   pair_a_q, pair_b_q;
    logic               done_q;

    assign start_ok = (state_q == IDLE) && bus.start;
    assign wr_ok    = (state_q == IDLE) && bus.wr_en;
    assign wr_box   = '{x1: bus.wr_x1, y1: bus.wr_y1, x2: bus.wr_x2, y2: bus.wr_y2};

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SCAN;
                    i_d     = '0;
                    j_d     = IDX_W'(1);
                end
            end
            SCAN: begin
                issue = 1'b1;
                if (j_q == LAST_J) begin
                    if (i_q == LAST_I) begin
                        state_d = FLUSH;
                    end else begin
                        i_d = i_q + IDX_W'(1);
                        j_d = i_q + IDX_W'(2);
                    end
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Coordinates need no reset: an entry is ignored until its act flag is written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tbl_q[bus.wr_idx] <= wr_box;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_q <= '0;
        end else if (wr_ok) begin
            act_q[bus.wr_idx] <= bus.wr_act;
        end
    end

    box_overlap_cmp u_cmp (
        .a_i       (tbl_q[i_q]),
        .b_i       (tbl_q[j_q]),
        .overlap_o (overlap)
    );

    assign hit = issue && act_q[i_q] && act_q[j_q] && overlap;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_mask_q <= '0;
            pair_vld_q <= 1'b0;
            pair_a_q   <= '0;
            pair_b_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            pair_vld_q <= hit;
            done_q     <= (state_q == FLUSH);
            if (start_ok) begin
                hit_mask_q <= '0;
            end else if (hit) begin
                hit_mask_q[i_q] <= 1'b1;
                hit_mask_q[j_q] <= 1'b1;
            end
            if (hit) begin
                pair_a_q <= i_q;
                pair_b_q <= j_q;
            end
        end
    end

`ifdef COLLISION_IRQ_EN
    logic irq_q;

    // hit_mask is final during FLUSH, so raising here lines irq up with done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if ((state_q == FLUSH) && (|hit_mask_q)) begin
            irq_q <= 1'b1;
        end else if (bus.irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.irq = irq_q;
`endif

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.hit_mask = hit_mask_q;
    assign bus.pair_vld = pair_vld_q;
    assign bus.pair_a   = pair_a_q;
    assign bus.pair_b   = pair_b_q;

endmodule

`default_nettype wire

// File: tb/tb_collision_scheduler.sv
// ============================================================================
//  Module      : tb_collision_scheduler
//  Description : Directed table-driven bench for collision_scheduler
//                (irq checks enabled with COLLISION_IRQ_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_collision_scheduler;
    import collision_pkg::*;

    localparam int NUM_OBJ   = 8;
    localparam int EXP_LAT   = NUM_OBJ * (NUM_OBJ - 1) / 2 + 2;
    localparam int EXP_BUSY  = EXP_LAT - 1;
    localparam int NUM_VEC   = 12;

    typedef struct {
        int          a;
        int          b;
        bit          act_a;
        bit          act_b;
        box_t        box_a;
        box_t        box_b;
        logic [7:0]  exp_mask;
        int          exp_n;
        int          exp_pa;
        int          exp_pb;
        bit          disturb;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [5:0] pairs [$];
    vec_t vecs [NUM_VEC];

    collision_if #(.NUM_OBJ(NUM_OBJ), .POS_W(POS_W)) bus ();

    collision_scheduler #(.NUM_OBJ(NUM_OBJ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic box_t mk(input int x1, input int y1, input int x2, input int y2);
        box_t b;
        b.x1 = x1[POS_W-1:0];
        b.y1 = y1[POS_W-1:0];
        b.x2 = x2[POS_W-1:0];
        b.y2 = y2[POS_W-1:0];
        return b;
    endfunction

    function automatic vec_t mkv(input int a, input int b, input bit aa, input bit ab,
                                 input box_t ba, input box_t bb, input logic [7:0] m,
                                 input int n, input int pa, input int pb, input bit d);
        vec_t v;
        v.a = a; v.b = b; v.act_a = aa; v.act_b = ab; v.box_a = ba; v.box_b = bb;
        v.exp_mask = m; v.exp_n = n; v.exp_pa = pa; v.exp_pb = pb; v.disturb = d;
        return v;
    endfunction

    task automatic drive_box(input int idx, input bit act, input box_t b);
        bus.wr_idx = 3'(idx);
        bus.wr_act = act;
        bus.wr_x1  = b.x1;
        bus.wr_y1  = b.y1;
        bus.wr_x2  = b.x2;
        bus.wr_y2  = b.y2;
    endtask

    task automatic wr_slot(input int idx, input bit act, input box_t b);
        @(negedge clk);
        bus.wr_en = 1'b1;
        drive_box(idx, act, b);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic clear_table();
        for (int s = 0; s < NUM_OBJ; s++) wr_slot(s, 1'b0, mk(0, 0, 0, 0));
    endtask

    // Cycle k counts from the start cycle (k=0); outputs are sampled on negedges.
    task automatic run_scan(input bit disturb, input bit wr_with, input int widx, input box_t wbox,
                            output int lat, output int np, output int pa, output int pb,
                            output logic irq_d, output int bcnt);
        lat = 999; np = 0; pa = -1; pb = -1; irq_d = 1'b0; bcnt = 0;
        pairs.delete();
        @(negedge clk);
        bus.start = 1'b1;
        if (wr_with) begin
            bus.wr_en = 1'b1;
            drive_box(widx, 1'b1, wbox);
        end
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (disturb && k == 5) begin
                bus.start = 1'b1;
                bus.wr_en = 1'b1;
                drive_box(0, 1'b1, mk(0, 0, 4095, 4095));
            end
            if (bus.busy) bcnt++;
            if (bus.pair_vld) begin
                if (np == 0) begin
                    pa = int'(bus.pair_a);
                    pb = int'(bus.pair_b);
                end
                np++;
                pairs.push_back({bus.pair_a, bus.pair_b});
            end
            if (bus.done) begin
                lat = k;
`ifdef COLLISION_IRQ_EN
                irq_d = bus.irq;
`endif
                break;
            end
        end
    endtask

    initial begin
        int   lat, np, pa, pb, bcnt, idx, dcnt;
        logic irq_d;
        logic [5:0] got;

        vecs[0]  = mkv(0, 1, 0, 0, mk(0, 0, 10, 10),       mk(5, 5, 15, 15),         8'h00, 0, 0, 0, 0);
        vecs[1]  = mkv(0, 3, 1, 1, mk(10, 10, 20, 20),     mk(15, 15, 25, 25),       8'h09, 1, 0, 3, 0);
        vecs[2]  = mkv(1, 2, 1, 1, mk(0, 0, 10, 10),       mk(10, 0, 20, 10),        8'h00, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 2, 1, 1, mk(0, 0, 10, 10),       mk(9, 0, 20, 10),         8'h06, 1, 1, 2, 0);
        vecs[4]  = mkv(4, 5, 1, 0, mk(0, 0, 10, 10),       mk(0, 0, 10, 10),         8'h00, 0, 0, 0, 0);
        vecs[5]  = mkv(2, 6, 1, 1, mk(0, 0, 10, 10),       mk(0, 10, 10, 20),        8'h00, 0, 0, 0, 0);
        vecs[6]  = mkv(0, 7, 1, 1, mk(5, 5, 5, 20),        mk(0, 0, 20, 20),         8'h00, 0, 0, 0, 0);
        vecs[7]  = mkv(6, 7, 1, 1, mk(0, 0, 4095, 4095),   mk(4094, 4094, 4095, 4095), 8'hC0, 1, 6, 7, 0);
        vecs[8]  = mkv(5, 2, 1, 1, mk(100, 100, 200, 200), mk(120, 130, 140, 150),   8'h24, 1, 2, 5, 0);
        vecs[9]  = mkv(3, 4, 1, 1, mk(100, 0, 200, 10),    mk(0, 0, 100, 10),        8'h00, 0, 0, 0, 0);
        vecs[10] = mkv(0, 1, 1, 1, mk(4000, 0, 4095, 10),  mk(0, 0, 100, 10),        8'h00, 0, 0, 0, 0);
        vecs[11] = mkv(0, 3, 1, 1, mk(10, 10, 20, 20),     mk(15, 15, 25, 25),       8'h09, 1, 0, 3, 1);

        reset_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        drive_box(0, 1'b0, mk(0, 0, 0, 0));
`ifdef COLLISION_IRQ_EN
        bus.irq_ack = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy",     32'(bus.busy),     0);
        chk("reset_done",     32'(bus.done),     0);
        chk("reset_hit_mask", 32'(bus.hit_mask), 0);
        chk("reset_pair_vld", 32'(bus.pair_vld), 0);
        chk("reset_pair_a",   32'(bus.pair_a),   0);
        chk("reset_pair_b",   32'(bus.pair_b),   0);
`ifdef COLLISION_IRQ_EN
        chk("reset_irq",      32'(bus.irq),      0);
`endif
        reset_n = 1'b1;

        // Empty table straight out of reset.
        run_scan(0, 0, 0, mk(0, 0, 0, 0), lat, np, pa, pb, irq_d, bcnt);
        chk("empty_latency", 32'(lat),  32'(EXP_LAT));
        chk("empty_mask",    32'(bus.hit_mask), 0);
        chk("empty_pairs",   32'(np),   0);
        chk("empty_busy",    32'(bcnt), 32'(EXP_BUSY));

        for (int v = 0; v < NUM_VEC; v++) begin
            clear_table();
            wr_slot(vecs[v].a, vecs[v].act_a, vecs[v].box_a);
            wr_slot(vecs[v].b, vecs[v].act_b, vecs[v].box_b);
            run_scan(vecs[v].disturb, 0, 0, mk(0, 0, 0, 0), lat, np, pa, pb, irq_d, bcnt);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(EXP_LAT));
            chk($sformatf("vec%0d_mask", v),    32'(bus.hit_mask), 32'(vecs[v].exp_mask));
            chk($sformatf("vec%0d_npairs", v),  32'(np),  32'(vecs[v].exp_n));
            if (vecs[v].exp_n == 1) begin
                chk($sformatf("vec%0d_pair_a", v), 32'(pa), 32'(vecs[v].exp_pa));
                chk($sformatf("vec%0d_pair_b", v), 32'(pb), 32'(vecs[v].exp_pb));
            end
            // Mask must survive past done.
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_mask_hold", v), 32'(bus.hit_mask), 32'(vecs[v].exp_mask));
        end

        // Every slot overlaps every other.
        for (int s = 0; s < NUM_OBJ; s++) wr_slot(s, 1'b1, mk(0, 0, 4095, 4095));
        run_scan(0, 0, 0, mk(0, 0, 0, 0), lat, np, pa, pb, irq_d, bcnt);
        chk("full_latency", 32'(lat), 32'(EXP_LAT));
        chk("full_npairs",  32'(np),  32'(NUM_OBJ * (NUM_OBJ - 1) / 2));
        chk("full_mask",    32'(bus.hit_mask), 32'hFF);
        idx = 0;
        for (int i = 0; i < NUM_OBJ - 1; i++) begin
            for (int j = i + 1; j < NUM_OBJ; j++) begin
                got = (idx < pairs.size()) ? pairs[idx] : 6'h3F;
                chk($sformatf("full_order_%0d", idx), 32'(got), 32'({i[2:0], j[2:0]}));
                idx++;
            end
        end

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_busy_before", 32'(bus.busy),     1);
        chk("midrst_vld_before",  32'(bus.pair_vld), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy",     32'(bus.busy),     0);
        chk("midrst_done",     32'(bus.done),     0);
        chk("midrst_mask",     32'(bus.hit_mask), 0);
        chk("midrst_pair_vld", 32'(bus.pair_vld), 0);
        chk("midrst_pair_a",   32'(bus.pair_a),   0);
        chk("midrst_pair_b",   32'(bus.pair_b),   0);
        reset_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 0);
        run_scan(0, 0, 0, mk(0, 0, 0, 0), lat, np, pa, pb, irq_d, bcnt);
        chk("midrst_act_cleared_mask", 32'(bus.hit_mask), 0);
        chk("midrst_act_cleared_np",   32'(np), 0);

        // Write landing in the same cycle as start.
        clear_table();
        wr_slot(0, 1'b1, mk(0, 0, 10, 10));
        run_scan(0, 1, 5, mk(5, 5, 15, 15), lat, np, pa, pb, irq_d, bcnt);
        chk("wrstart_latency", 32'(lat), 32'(EXP_LAT));
        chk("wrstart_mask",    32'(bus.hit_mask), 32'h21);
        chk("wrstart_pair_a",  32'(pa), 0);
        chk("wrstart_pair_b",  32'(pb), 5);

`ifdef COLLISION_IRQ_EN
        @(negedge clk);
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        chk("irq_ack_initial", 32'(bus.irq), 0);
        run_scan(0, 0, 0, mk(0, 0, 0, 0), lat, np, pa, pb, irq_d, bcnt);
        chk("irq_at_done", 32'(irq_d), 1);
        repeat (3) @(negedge clk);
        chk("irq_sticky", 32'(bus.irq), 1);
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        chk("irq_cleared", 32'(bus.irq), 0);
        bus.irq_ack = 1'b1;
        run_scan(0, 0, 0, mk(0, 0, 0, 0), lat, np, pa, pb, irq_d, bcnt);
        bus.irq_ack = 1'b0;
        chk("irq_set_wins", 32'(irq_d), 1);
        @(negedge clk);
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        clear_table();
        run_scan(0, 0, 0, mk(0, 0, 0, 0), lat, np, pa, pb, irq_d, bcnt);
        chk("irq_no_hits", 32'(irq_d), 0);
        repeat (2) @(negedge clk);
        chk("irq_no_hits_after", 32'(bus.irq), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
